// File: rtl/preif_fetch_gen.sv
// Pre-IF fetch address generator: owns the fetch PC, arbitrates redirect
// channels, issues I-cache/ITLB requests and tracks outstanding requests in
// an in-order FIFO so stale responses can be squashed after a redirect.
module preif_fetch_gen #(
   parameter int unsigned FETCH_WIDTH    = 2,
   parameter int unsigned NUM_REDIR      = 4,
   parameter int unsigned INFLIGHT_DEPTH = 4,
   parameter logic [31:0] RESET_PC       = 32'hBFC0_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall_i,
   input  logic [NUM_REDIR-1:0]      redir_valid_i,
   input  logic [NUM_REDIR*32-1:0]   redir_pc_i,
   output logic                      fetch_req_valid_o,
   input  logic                      fetch_req_ready_i,
   output logic [31:0]               fetch_req_pc_o,
   input  logic                      fetch_resp_valid_i,
   output logic                      out_valid_o,
   output logic [31:0]               out_pc_o,
   output logic [FETCH_WIDTH-1:0]    out_mask_o,
   output logic                      adel_o,
   output logic [31:0]               adel_pc_o
);

   localparam int unsigned PTR_W       = (INFLIGHT_DEPTH > 1) ? $clog2(INFLIGHT_DEPTH) : 1;
   localparam int unsigned CNT_W       = PTR_W + 1;
   localparam logic [31:0] GROUP_BYTES = 32'(FETCH_WIDTH * 4);
   localparam logic [31:0] GROUP_MASK  = GROUP_BYTES - 32'd1;
   localparam logic [31:0] LANE_MASK   = 32'(FETCH_WIDTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(INFLIGHT_DEPTH);

   logic [31:0]               pc_q, pc_d;
   logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [INFLIGHT_DEPTH-1:0] live_q, live_d;
   logic [31:0]               fifo_pc_q [INFLIGHT_DEPTH];

   logic        redir_any;
   logic [31:0] redir_pc;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pc_aligned;
   logic        req_valid;
   logic        push;
   logic        pop;
   logic        head_live;
   logic [31:0] head_pc;
   logic [31:0] lane_off;

   // Redirect arbitration: scan from the top so the lowest asserted channel wins.
   always_comb begin
      redir_any = |redir_valid_i;
      redir_pc  = '0;
      for (int unsigned k = NUM_REDIR; k > 0; k--) begin
         if (redir_valid_i[k-1]) begin
            redir_pc = redir_pc_i[32*(k-1) +: 32];
         end
      end
   end

   // Request qualification, FIFO handshakes and head-entry view.
   always_comb begin
      fifo_full  = (cnt_q == FULL_CNT);
      fifo_empty = (cnt_q == '0);
      pc_aligned = (pc_q[1:0] == 2'b00);
      req_valid  = !rst && !stall_i && !fifo_full && pc_aligned && !redir_any;
      push       = req_valid && fetch_req_ready_i;
      pop        = !rst && fetch_resp_valid_i && !fifo_empty;
      head_live  = live_q[rd_ptr_q];
      head_pc    = fifo_pc_q[rd_ptr_q];
      lane_off   = (head_pc >> 2) & LANE_MASK;
   end

   // Next PC: redirect beats handshake; handshake advances to the next aligned group.
   always_comb begin
      pc_d = pc_q;
      if (redir_any) begin
         pc_d = redir_pc;
      end else if (push) begin
         pc_d = (pc_q & ~GROUP_MASK) + GROUP_BYTES;
      end
   end

   // FIFO bookkeeping; a redirect kills every entry, including the one popped this cycle.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      live_d   = live_q;
      if (push) begin
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         live_d[wr_ptr_q] = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (redir_any) begin
         live_d = '0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         live_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         live_q   <= live_d;
      end
   end

   // FIFO payload storage; contents are only meaningful under cnt_q/live_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q] <= pc_q;
      end
   end

   // Output drive; data outputs are forced to zero when not qualified.
   always_comb begin
      fetch_req_valid_o = req_valid;
      fetch_req_pc_o    = rst ? '0 : pc_q;
      adel_o            = !rst && !pc_aligned;
      adel_pc_o         = adel_o ? pc_q : '0;
      out_valid_o       = pop && head_live && !redir_any;
      out_pc_o          = out_valid_o ? head_pc : '0;
      out_mask_o        = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         out_mask_o[i] = out_valid_o && (32'(i) >= lane_off);
      end
   end

endmodule

// File: tb/tb_preif_fetch_gen.sv
// Directed self-checking bench for preif_fetch_gen (FETCH_WIDTH=2, NUM_REDIR=4,
// INFLIGHT_DEPTH=4). Inputs change 1ns after the rising edge; outputs are
// sampled 1ns later, well away from the next edge.
module tb_preif_fetch_gen;

   localparam int unsigned FW = 2;
   localparam int unsigned NR = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall_i;
   logic [NR-1:0]     redir_valid_i;
   logic [NR*32-1:0]  redir_pc_i;
   logic              fetch_req_valid_o;
   logic              fetch_req_ready_i;
   logic [31:0]       fetch_req_pc_o;
   logic              fetch_resp_valid_i;
   logic              out_valid_o;
   logic [31:0]       out_pc_o;
   logic [FW-1:0]     out_mask_o;
   logic              adel_o;
   logic [31:0]       adel_pc_o;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   always #5 clk = ~clk;

   preif_fetch_gen #(
      .FETCH_WIDTH   (FW),
      .NUM_REDIR     (NR),
      .INFLIGHT_DEPTH(4),
      .RESET_PC      (32'hBFC0_0000)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stall_i           (stall_i),
      .redir_valid_i     (redir_valid_i),
      .redir_pc_i        (redir_pc_i),
      .fetch_req_valid_o (fetch_req_valid_o),
      .fetch_req_ready_i (fetch_req_ready_i),
      .fetch_req_pc_o    (fetch_req_pc_o),
      .fetch_resp_valid_i(fetch_resp_valid_i),
      .out_valid_o       (out_valid_o),
      .out_pc_o          (out_pc_o),
      .out_mask_o        (out_mask_o),
      .adel_o            (adel_o),
      .adel_pc_o         (adel_pc_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic redir(input logic [3:0] v, input logic [31:0] target);
      redir_valid_i = v;
      for (int k = 0; k < 4; k++) begin
         redir_pc_i[32*k +: 32] = v[k] ? target : 32'h0;
      end
   endtask

   task automatic chk_req(input string tag, input logic v, input logic [31:0] pc);
      chk({tag, ".v"}, 32'(fetch_req_valid_o), 32'(v));
      chk({tag, ".pc"}, fetch_req_pc_o, pc);
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [1:0] m);
      chk({tag, ".ov"}, 32'(out_valid_o), 32'(v));
      chk({tag, ".opc"}, out_pc_o, pc);
      chk({tag, ".om"}, 32'(out_mask_o), 32'(m));
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; redir_valid_i = '0; redir_pc_i = '0;
      fetch_req_ready_i = 1'b1; fetch_resp_valid_i = 1'b0;
      tick(); tick();

      // Reset state
      fetch_resp_valid_i = 1'b1;
      settle();
      chk_req("rst", 1'b0, 32'h0);
      chk_out("rst", 1'b0, 32'h0, 2'b00);
      chk("rst.adel", 32'(adel_o), 32'd0);
      fetch_resp_valid_i = 1'b0;

      // Four back-to-back requests fill the FIFO
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk_req("fill", 1'b1, 32'hBFC0_0000 + 32'(8 * i));
         tick();
      end
      settle();
      chk_req("full", 1'b0, 32'hBFC0_0020);
      fetch_resp_valid_i = 1'b1;
      settle();
      chk_out("resp0", 1'b1, 32'hBFC0_0000, 2'b11);
      tick();
      fetch_resp_valid_i = 1'b0; fetch_req_ready_i = 1'b0;
      settle();
      chk_req("after_pop", 1'b1, 32'hBFC0_0020);

      // Drain the remaining three
      fetch_resp_valid_i = 1'b1;
      for (int i = 1; i < 4; i++) begin
         settle();
         chk_out("drain", 1'b1, 32'hBFC0_0000 + 32'(8 * i), 2'b11);
         tick();
      end
      // Response while empty is ignored
      settle();
      chk_out("empty", 1'b0, 32'h0, 2'b00);
      tick();
      fetch_resp_valid_i = 1'b0;

      // Redirect on channel 2 to a mid-group PC
      redir(4'b0100, 32'h8000_0184);
      settle();
      chk("redir.v", 32'(fetch_req_valid_o), 32'd0);
      tick();
      redir(4'b0000, 32'h0); fetch_req_ready_i = 1'b1;
      settle();
      chk_req("r184", 1'b1, 32'h8000_0184);
      tick();
      fetch_req_ready_i = 1'b0;
      settle();
      chk_req("r188", 1'b1, 32'h8000_0188);
      fetch_resp_valid_i = 1'b1;
      settle();
      chk_out("r184resp", 1'b1, 32'h8000_0184, 2'b10);
      tick();
      fetch_resp_valid_i = 1'b0;

      // Three in flight, then redirect squashes them
      fetch_req_ready_i = 1'b1;
      tick(); tick(); tick();
      fetch_req_ready_i = 1'b0;
      redir(4'b0001, 32'h8000_1000);
      tick();
      redir(4'b0000, 32'h0); fetch_req_ready_i = 1'b1;
      settle();
      chk_req("sq.req", 1'b1, 32'h8000_1000);
      tick();
      fetch_req_ready_i = 1'b0; fetch_resp_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk_out("squash", 1'b0, 32'h0, 2'b00);
         tick();
      end
      settle();
      chk_out("sq.live", 1'b1, 32'h8000_1000, 2'b11);
      tick();
      fetch_resp_valid_i = 1'b0;

      // Two simultaneous redirects: channel 1 beats channel 3
      redir_valid_i = 4'b1010;
      redir_pc_i = '0;
      redir_pc_i[63:32]  = 32'h8000_0200;
      redir_pc_i[127:96] = 32'h8000_0300;
      tick();
      redir(4'b0000, 32'h0);
      settle();
      chk_req("prio", 1'b1, 32'h8000_0200);

      // Misaligned redirect raises AdEL and holds
      redir(4'b0001, 32'h8000_0002);
      tick();
      redir(4'b0000, 32'h0); fetch_req_ready_i = 1'b1;
      settle();
      chk("adel", 32'(adel_o), 32'd1);
      chk("adel.pc", adel_pc_o, 32'h8000_0002);
      chk("adel.v", 32'(fetch_req_valid_o), 32'd0);
      tick();
      settle();
      chk("adel.hold", fetch_req_pc_o, 32'h8000_0002);
      fetch_req_ready_i = 1'b0;
      redir(4'b0001, 32'h8000_0000);
      tick();
      redir(4'b0000, 32'h0);
      settle();
      chk("adel.clr", 32'(adel_o), 32'd0);
      chk_req("aligned", 1'b1, 32'h8000_0000);

      // Two in flight, reset pulse discards them
      fetch_req_ready_i = 1'b1;
      tick(); tick();
      fetch_req_ready_i = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      chk_req("rst2", 1'b1, 32'hBFC0_0000);
      fetch_resp_valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk_out("rst2.resp", 1'b0, 32'h0, 2'b00);
         tick();
      end
      fetch_resp_valid_i = 1'b0;
      settle();
      chk_req("rst2.again", 1'b1, 32'hBFC0_0000);

      // Stall suppresses the request
      stall_i = 1'b1;
      settle();
      chk("stall", 32'(fetch_req_valid_o), 32'd0);
      stall_i = 1'b0;

      // 32-bit wrap of the sequential PC
      redir(4'b1000, 32'hFFFF_FFF8);
      tick();
      redir(4'b0000, 32'h0); fetch_req_ready_i = 1'b1;
      tick();
      fetch_req_ready_i = 1'b0;
      settle();
      chk_req("wrap", 1'b1, 32'h0000_0000);
      fetch_resp_valid_i = 1'b1;
      settle();
      chk_out("wrap.resp", 1'b1, 32'hFFFF_FFF8, 2'b11);
      tick();
      fetch_resp_valid_i = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
